// File: rtl/video_axis_pkg.sv
// Shared types for the video AXI-stream crop path: default widths, crop FSM
// states and the beat layout carried through the output slice.
package video_axis_pkg;

  localparam int PIX_W = 24;
  localparam int CRD_W = 16;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACTIVE   = 2'd1,
    DONE     = 2'd2
  } crop_state_e;

  typedef struct packed {
    logic             user;
    logic             last;
    logic [PIX_W-1:0] data;
  } beat_t;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry output register slice; entry 0 drives the master side directly so
// the output holds steady while the consumer stalls.
module axis_skid_buf
  import video_axis_pkg::*;
#(
  parameter int W = PIX_W + 2
) (
  input  logic         vid_clk,
  input  logic         rst_n,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [1:0]   level
);

  logic [W-1:0] ent0, ent1;
  logic [1:0]   cnt;
  logic         push, pop;

  assign s_ready = (cnt != 2'd2);
  assign push    = s_valid & s_ready;
  assign pop     = (cnt != 2'd0) & m_ready;
  assign m_valid = (cnt != 2'd0);
  assign m_data  = ent0;
  assign level   = cnt;

  always_ff @(posedge vid_clk) begin
    if (!rst_n) begin
      ent0 <= '0;
      ent1 <= '0;
      cnt  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) ent0 <= s_data;
          else             ent1 <= s_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          // push needs a free slot, so only the one-entry case occurs here
          if (cnt == 2'd1) ent0 <= s_data;
          else begin
            ent0 <= ent1;
            ent1 <= s_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/video_axis_crop.sv
// Cuts a rectangular window out of an AXI4-Stream video frame (tuser=SOF,
// tlast=EOL) and re-emits it as a well-formed stream through a skid slice.
module video_axis_crop
  import video_axis_pkg::*;
#(
  parameter int DW = PIX_W,
  parameter int CW = CRD_W
) (
  input  logic          vid_clk,
  input  logic          rst_n,
  input  logic [DW-1:0] s_axis_tdata,
  input  logic          s_axis_tuser,
  input  logic          s_axis_tlast,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  output logic [DW-1:0] m_axis_tdata,
  output logic          m_axis_tuser,
  output logic          m_axis_tlast,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  input  logic [CW-1:0] crop_x,
  input  logic [CW-1:0] crop_y,
  input  logic [CW-1:0] crop_w,
  input  logic [CW-1:0] crop_h,
  output logic          frame_done,
  output logic          overflow_err,
  output logic          short_line_err,
  input  logic          err_clr
);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  crop_state_e   state;
  logic [CW-1:0] x_q, y_q, sx_q, sy_q, sw_q, sh_q;
  logic          first_pend;

  logic          acc;
  logic [CW-1:0] x_c, y_c, cx, cy, cw, ch;
  logic [CW:0]   x_lim, y_lim, x_nx, y_nx;
  logic          act, win_zero, x_in, y_in, in_win;
  logic          o_last, o_user, o_done, short_hit;

  assign acc = s_axis_tvalid & s_axis_tready;

  // An SOF beat is judged at (0,0) against the crop values it latches.
  assign x_c = s_axis_tuser ? '0 : x_q;
  assign y_c = s_axis_tuser ? '0 : y_q;
  assign cx  = s_axis_tuser ? crop_x : sx_q;
  assign cy  = s_axis_tuser ? crop_y : sy_q;
  assign cw  = s_axis_tuser ? crop_w : sw_q;
  assign ch  = s_axis_tuser ? crop_h : sh_q;

  assign x_lim = {1'b0, cx} + {1'b0, cw};
  assign y_lim = {1'b0, cy} + {1'b0, ch};
  assign x_nx  = {1'b0, x_c} + 1'b1;
  assign y_nx  = {1'b0, y_c} + 1'b1;

  assign act       = s_axis_tuser | (state == ACTIVE);
  assign win_zero  = (cw == '0) | (ch == '0);
  assign x_in      = (x_c >= cx) & ({1'b0, x_c} < x_lim);
  assign y_in      = (y_c >= cy) & ({1'b0, y_c} < y_lim);
  assign in_win    = acc & act & !win_zero & x_in & y_in;
  assign o_last    = in_win & ((x_nx == x_lim) | s_axis_tlast);
  assign o_user    = in_win & (s_axis_tuser | first_pend);
  assign o_done    = o_last & (y_nx == y_lim);
  assign short_hit = in_win & s_axis_tlast & (x_nx != x_lim);

  always_ff @(posedge vid_clk) begin
    if (!rst_n) begin
      state      <= WAIT_SOF;
      x_q        <= '0;
      y_q        <= '0;
      sx_q       <= '0;
      sy_q       <= '0;
      sw_q       <= '0;
      sh_q       <= '0;
      first_pend <= 1'b0;
    end else if (acc) begin
      if (s_axis_tuser) begin
        sx_q <= crop_x;
        sy_q <= crop_y;
        sw_q <= crop_w;
        sh_q <= crop_h;
      end
      if (s_axis_tlast) begin
        x_q <= '0;
        y_q <= sat_inc(y_c);
      end else begin
        x_q <= sat_inc(x_c);
        y_q <= y_c;
      end
      if (s_axis_tuser)  first_pend <= !in_win;
      else if (in_win)   first_pend <= 1'b0;
      if (s_axis_tuser)
        state <= (win_zero || o_done) ? DONE : ACTIVE;
      else if (state == ACTIVE && o_done)
        state <= DONE;
    end
  end

  // Evaluation stage feeding the skid slice.
  beat_t      ev_beat;
  logic       ev_vld, ev_done;
  logic       sk_ready, sk_push, sk_pop, ev_nx;
  logic [1:0] sk_level, lvl_nx;
  logic [2:0] occ_nx;

  assign sk_push = ev_vld & sk_ready;
  assign sk_pop  = m_axis_tvalid & m_axis_tready;
  assign lvl_nx  = sk_level + {1'b0, sk_push} - {1'b0, sk_pop};
  assign ev_nx   = in_win | (ev_vld & !sk_push);
  assign occ_nx  = {1'b0, lvl_nx} + {2'b00, ev_nx};

  always_ff @(posedge vid_clk) begin
    if (!rst_n) begin
      ev_vld  <= 1'b0;
      ev_beat <= '0;
      ev_done <= 1'b0;
    end else if (in_win) begin
      ev_vld       <= 1'b1;
      ev_beat.user <= o_user;
      ev_beat.last <= o_last;
      ev_beat.data <= s_axis_tdata;
      ev_done      <= o_done;
    end else if (sk_push) begin
      ev_vld <= 1'b0;
    end
  end

  // Ready closes when the slice is full, or when two beats are pending and the
  // consumer is stalled; a stalled evaluation beat then never meets a new one.
  always_ff @(posedge vid_clk) begin
    if (!rst_n) begin
      s_axis_tready  <= 1'b1;
      frame_done     <= 1'b0;
      overflow_err   <= 1'b0;
      short_line_err <= 1'b0;
    end else begin
      s_axis_tready  <= !((lvl_nx == 2'd2) || ((occ_nx >= 3'd2) && !m_axis_tready));
      frame_done     <= sk_push & ev_done;
      overflow_err   <= (s_axis_tvalid & !s_axis_tready) | (overflow_err & !err_clr);
      short_line_err <= short_hit | (short_line_err & !err_clr);
    end
  end

  axis_skid_buf #(.W(DW + 2)) u_skid (
    .vid_clk (vid_clk),
    .rst_n   (rst_n),
    .s_data  ({ev_beat.user, ev_beat.last, ev_beat.data}),
    .s_valid (ev_vld),
    .s_ready (sk_ready),
    .m_data  ({m_axis_tuser, m_axis_tlast, m_axis_tdata}),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready),
    .level   (sk_level)
  );

endmodule

// File: tb/tb_video_axis_crop.sv
// Scoreboard bench for video_axis_crop: directed frames push expected beats,
// a negedge monitor pops and compares every accepted output beat.
module tb_video_axis_crop;

  logic        vid_clk = 1'b0;
  logic        rst_n;
  logic [23:0] s_axis_tdata;
  logic        s_axis_tuser, s_axis_tlast, s_axis_tvalid, s_axis_tready;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tuser, m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic [15:0] crop_x, crop_y, crop_w, crop_h;
  logic        frame_done, overflow_err, short_line_err, err_clr;

  always #5 vid_clk = ~vid_clk;

  video_axis_crop dut (
    .vid_clk(vid_clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .crop_x(crop_x), .crop_y(crop_y), .crop_w(crop_w), .crop_h(crop_h),
    .frame_done(frame_done), .overflow_err(overflow_err), .short_line_err(short_line_err),
    .err_clr(err_clr)
  );

  int          n_cmp = 0, n_bad = 0, fd_cnt = 0;
  logic [25:0] expq[$];
  logic        tog_en = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: scoreboard pops, hold-while-stalled, frame_done counting.
  logic [25:0] prev_beat;
  logic        prev_stall = 1'b0;
  always @(negedge vid_clk) begin
    logic [25:0] cur, e;
    cur = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    if (!rst_n) prev_stall = 1'b0;
    else begin
      if (prev_stall) chk("hold", {6'd0, cur}, {6'd0, prev_beat});
      if (m_axis_tvalid && m_axis_tready) begin
        if (expq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected beat: got %0h, expected none", cur);
        end else begin
          e = expq.pop_front();
          chk("beat", {6'd0, cur}, {6'd0, e});
        end
      end
      if (frame_done) fd_cnt++;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = cur;
    end
  end

  task automatic cyc();
    @(posedge vid_clk);
    #1;
    if (tog_en) m_axis_tready = !m_axis_tready;
  endtask

  task automatic ex(int x, int y, int f, logic u, logic l);
    expq.push_back({u, l, f[7:0], y[7:0], x[7:0]});
  endtask

  task automatic drive(int x, int y, int f, int w);
    s_axis_tdata  = {f[7:0], y[7:0], x[7:0]};
    s_axis_tuser  = (x == 0 && y == 0);
    s_axis_tlast  = (x == w - 1);
    s_axis_tvalid = 1'b1;
    cyc();
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_frame(int w, int h, int f, int gap, int chg_idx, logic [15:0] chg_x);
    int idx = 0;
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        if (idx == chg_idx) crop_x = chg_x;
        drive(x, y, f, w);
        idx++;
        for (int g = 0; g < gap; g++) cyc();
      end
  endtask

  task automatic drain(string nm);
    int t = 0;
    while (expq.size() != 0 && t < 300) begin cyc(); t++; end
    chk({nm, "_drain"}, expq.size(), 0);
    repeat (4) cyc();
  endtask

  task automatic set_crop(int x, int y, int w, int h);
    crop_x = x[15:0]; crop_y = y[15:0]; crop_w = w[15:0]; crop_h = h[15:0];
  endtask

  task automatic clear_errs();
    err_clr = 1'b1; cyc(); err_clr = 1'b0; cyc();
  endtask

  task automatic exp_t1(int f);
    ex(2, 1, f, 1, 0); ex(3, 1, f, 0, 0); ex(4, 1, f, 0, 1);
    ex(2, 2, f, 0, 0); ex(3, 2, f, 0, 0); ex(4, 2, f, 0, 1);
  endtask

  initial begin
    int fd0;
    logic [7:0] rdy_exp;
    rst_n = 1'b0; s_axis_tdata = '0; s_axis_tuser = 0; s_axis_tlast = 0; s_axis_tvalid = 0;
    m_axis_tready = 1'b1; err_clr = 1'b0;
    set_crop(2, 1, 3, 2);
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_m_tdata", m_axis_tdata, 0);
    chk("rst_m_tuser_tlast", {m_axis_tuser, m_axis_tlast}, 0);
    chk("rst_s_tready", s_axis_tready, 1);
    chk("rst_flags", {overflow_err, short_line_err, frame_done}, 0);

    // 1: basic 8x4 crop
    fd0 = fd_cnt;
    exp_t1(1);
    send_frame(8, 4, 1, 0, -1, 0);
    drain("t1");
    chk("t1_frame_done", fd_cnt - fd0, 1);
    chk("t1_errs", {overflow_err, short_line_err}, 0);

    // 2: toggling consumer, input with one idle cycle per beat
    fd0 = fd_cnt;
    exp_t1(2);
    tog_en = 1'b1;
    send_frame(8, 4, 2, 1, -1, 0);
    drain("t2");
    tog_en = 1'b0; m_axis_tready = 1'b1; cyc();
    chk("t2_frame_done", fd_cnt - fd0, 1);
    chk("t2_overflow", overflow_err, 0);

    // 3: consumer stalled 5 cycles under continuous input
    set_crop(0, 0, 8, 1);
    fd0 = fd_cnt;
    rdy_exp = 8'b1100_0011;
    ex(0, 0, 3, 1, 0); ex(1, 0, 3, 0, 0); ex(6, 0, 3, 0, 0); ex(7, 0, 3, 0, 1);
    for (int x = 0; x < 8; x++) begin
      m_axis_tready = (x >= 5);
      s_axis_tdata  = {8'd3, 8'd0, 8'(x)};
      s_axis_tuser  = (x == 0);
      s_axis_tlast  = (x == 7);
      s_axis_tvalid = 1'b1;
      chk($sformatf("t3_ready_c%0d", x), s_axis_tready, rdy_exp[x]);
      cyc();
    end
    s_axis_tvalid = 0; s_axis_tuser = 0; s_axis_tlast = 0;
    drain("t3");
    chk("t3_overflow", overflow_err, 1);
    chk("t3_short", short_line_err, 1);
    chk("t3_frame_done", fd_cnt - fd0, 1);
    clear_errs();
    chk("t3_clr", {overflow_err, short_line_err}, 0);

    // 4: window wider than the line
    set_crop(5, 0, 10, 1);
    fd0 = fd_cnt;
    ex(5, 0, 4, 1, 0); ex(6, 0, 4, 0, 0); ex(7, 0, 4, 0, 1);
    send_frame(8, 2, 4, 0, -1, 0);
    drain("t4");
    chk("t4_short", short_line_err, 1);
    chk("t4_overflow", overflow_err, 0);
    chk("t4_frame_done", fd_cnt - fd0, 1);
    clear_errs();

    // zero-width window: nothing forwarded, no frame_done
    set_crop(0, 0, 0, 2);
    fd0 = fd_cnt;
    send_frame(4, 2, 7, 0, -1, 0);
    drain("tz");
    chk("tz_frame_done", fd_cnt - fd0, 0);

    // 5: crop_x changed mid-frame applies on the next frame
    set_crop(2, 0, 2, 2);
    fd0 = fd_cnt;
    ex(2, 0, 5, 1, 0); ex(3, 0, 5, 0, 1); ex(2, 1, 5, 0, 0); ex(3, 1, 5, 0, 1);
    ex(0, 0, 6, 1, 0); ex(1, 0, 6, 0, 1); ex(0, 1, 6, 0, 0); ex(1, 1, 6, 0, 1);
    send_frame(6, 3, 5, 0, 3, 16'd0);
    send_frame(6, 3, 6, 0, -1, 0);
    drain("t5");
    chk("t5_frame_done", fd_cnt - fd0, 2);

    // 6: reset mid-window, then a fresh frame
    set_crop(2, 1, 3, 2);
    m_axis_tready = 1'b0;
    for (int x = 0; x < 8; x++) drive(x, 0, 8, 8);
    for (int x = 0; x < 4; x++) drive(x, 1, 8, 8);
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    chk("t6_rst_tvalid", m_axis_tvalid, 0);
    chk("t6_rst_tready", s_axis_tready, 1);
    m_axis_tready = 1'b1;
    repeat (3) cyc();
    fd0 = fd_cnt;
    exp_t1(9);
    send_frame(8, 4, 9, 0, -1, 0);
    drain("t6");
    chk("t6_frame_done", fd_cnt - fd0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
